// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED matrix pixel path.
//
// Contents:
//   ROWS, COLS, DW   default matrix geometry and pixel width (GRB 8:8:8)
//   NPIX, AW         pixel count and frame-buffer address width
//   reader_state_t   pixel_reader FSM states
//   serp_addr()      chain index -> frame-buffer address (serpentine wiring)
package led_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 24;
  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  // The LED chain snakes through the matrix: even rows run left to right,
  // odd rows run right to left. The frame buffer is stored row-major, so
  // odd rows need their column index mirrored. With a power-of-2 COLS the
  // divide/modulo reduce to bit slicing.
  function automatic int unsigned serp_addr(input int unsigned n,
                                            input int unsigned cols);
    int unsigned row;
    int unsigned col;
    row = n / cols;
    col = n % cols;
    if (row[0]) begin
      return row * cols + (cols - 1 - col);
    end
    return n;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo -- 2-entry FIFO that absorbs the one-cycle frame-buffer
// read latency so the reader can stream one pixel per cycle while still
// honouring backpressure from the LED transmitter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push              write push_data/push_last (ignored when full unless
//                     a pop happens in the same cycle)
//   push_data/last    entry being written
//   pop               remove head entry (ignored when empty)
//   full, empty       occupancy flags
//   data, last        head entry (all zero after reset)
module pixel_skid_fifo #(
  parameter int DW = led_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] data,
  output logic          last
);

  logic [DW-1:0] data_reg [2];
  logic          last_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign do_pop  = pop & ~empty;
  // Push into a full FIFO is legal only when the head leaves in the same
  // cycle; the freed slot is exactly the one wr_ptr points at.
  assign do_push = push & (~full | do_pop);

  assign data = data_reg[rd_ptr_reg];
  assign last = last_reg[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= '0;
        last_reg[i] <= 1'b0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        data_reg[wr_ptr_reg] <= push_data;
        last_reg[wr_ptr_reg] <= push_last;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pixel_reader.sv
// pixel_reader -- streams one frame from the frame buffer to the LED
// transmitter in serpentine chain order.
//
// Ports:
//   CLK, Rst       clock, asynchronous active-high reset
//   start          single-cycle frame request (ignored while busy)
//   busy           frame in progress
//   done           one-cycle pulse after the last pixel is accepted
//   rd_en/rd_addr  frame-buffer read request
//   rd_data        frame-buffer data, valid one cycle after rd_en
//   pix_valid/pix_ready/pix_data/pix_last
//                  ready/valid pixel stream; pix_last tags the final pixel
module pixel_reader #(
  parameter int  ROWS = led_pkg::ROWS,
  parameter int  COLS = led_pkg::COLS,
  parameter int  DW   = led_pkg::DW,
  localparam int NPIX = ROWS * COLS,
  localparam int AW   = $clog2(NPIX)
) (
  input  logic          CLK,
  input  logic          Rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [DW-1:0] pix_data,
  output logic          pix_last
);

  import led_pkg::*;

  reader_state_t state_reg;
  reader_state_t state_next;
  logic [AW-1:0] n_reg;
  logic [AW-1:0] n_next;
  logic          inflight_reg;
  logic          inflight_last_reg;
  logic          done_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_last;
  logic [DW-1:0] fifo_data;
  logic          pop;
  logic          last_accept;
  logic          is_last_n;
  logic [1:0]    buffered;
  logic [2:0]    pending;

  assign pix_valid   = ~fifo_empty;
  assign pop         = pix_valid & pix_ready;
  assign pix_data    = fifo_data;
  assign pix_last    = pix_valid & fifo_last;
  assign last_accept = pop & fifo_last;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign is_last_n   = (n_reg == AW'(NPIX - 1));
  assign rd_addr     = AW'(serp_addr(32'(n_reg), 32'(COLS)));

  // Pixels that will occupy the FIFO next cycle if no new read is issued:
  // what is buffered plus what is in flight, minus what leaves right now.
  // Counting the concurrent pop lets a steady ready=1 stream run at one
  // pixel per cycle with only two FIFO entries.
  assign buffered = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pending  = {1'b0, buffered} + {2'b00, inflight_reg} - {2'b00, pop};

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          n_next     = '0;
        end
      end
      FETCH: begin
        if (pending < 3'd2) begin
          rd_en  = 1'b1;
          n_next = n_reg + 1'b1;
          if (is_last_n) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_reg         <= IDLE;
      n_reg             <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      n_reg             <= n_next;
      // rd_data returns exactly one cycle after rd_en, so a single flag
      // tracks the read in flight along with its last-pixel tag.
      inflight_reg      <= rd_en;
      inflight_last_reg <= rd_en & is_last_n;
      done_reg          <= (state_reg == DRAIN) & last_accept;
    end
  end

  pixel_skid_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (Rst),
    .push      (inflight_reg),
    .push_data (rd_data),
    .push_last (inflight_last_reg),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .data      (fifo_data),
    .last      (fifo_last)
  );

endmodule
